// File: rtl/pipeline_ctrl_8085_pkg.sv
// ---------------------------------------------------------------------------
// pipe_8085_pkg
// Shared types and constants for the 8085 pipeline controller:
//   state_e   - controller state (RUN / HALTED)
//   pc_sel_e  - PC source select encodings driven on pc_sel
//   REG_W     - register index width (entries 0..6, index 7 never written)
//   stage_t   - shadow record of one pipeline stage {v, dst, wr, hlt}
//   stage_hit - true when a stage will write register r
// ---------------------------------------------------------------------------
package pipe_8085_pkg;

  localparam int unsigned REG_W = 3;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    PC_INC = 2'd0,  // sequential fetch, PC+1
    PC_BR  = 2'd1,  // taken branch target from EX
    PC_RST = 2'd2   // EX PC+1, the restart point after HLT
  } pc_sel_e;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dst;
    logic             wr;
    logic             hlt;
  } stage_t;

  // A stage produces register r if it is live, writes, and targets r.
  function automatic logic stage_hit(input logic             v,
                                     input logic             wr,
                                     input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] r);
    return v & wr & (dst == r);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_8085_hazard.sv
// ---------------------------------------------------------------------------
// hazard_detect_8085
// Combinational RAW comparator. Flags a hazard when the live ID instruction
// reads a register still being produced by the EX or WB stage. There is no
// forwarding, so a producer in either stage blocks the reader.
// Ports:
//   id_v_i              - ID holds a live instruction
//   src_a_i / use_a_i   - first source index and its read enable
//   src_b_i / use_b_i   - second source index and its read enable
//   ex_v_i/ex_wr_i/ex_dst_i - EX shadow: valid, writes, destination
//   wb_v_i/wb_wr_i/wb_dst_i - WB shadow: valid, writes, destination
//   raw_o               - read-after-write hazard present
// ---------------------------------------------------------------------------
module hazard_detect_8085 #(
  parameter int unsigned REG_W = 3
) (
  input  logic             id_v_i,
  input  logic [REG_W-1:0] src_a_i,
  input  logic             use_a_i,
  input  logic [REG_W-1:0] src_b_i,
  input  logic             use_b_i,
  input  logic             ex_v_i,
  input  logic             ex_wr_i,
  input  logic [REG_W-1:0] ex_dst_i,
  input  logic             wb_v_i,
  input  logic             wb_wr_i,
  input  logic [REG_W-1:0] wb_dst_i,
  output logic             raw_o
);
  import pipe_8085_pkg::*;

  logic hit_a;
  logic hit_b;

  always_comb begin
    hit_a = stage_hit(ex_v_i, ex_wr_i, ex_dst_i, src_a_i)
          | stage_hit(wb_v_i, wb_wr_i, wb_dst_i, src_a_i);
    hit_b = stage_hit(ex_v_i, ex_wr_i, ex_dst_i, src_b_i)
          | stage_hit(wb_v_i, wb_wr_i, wb_dst_i, src_b_i);
    raw_o = id_v_i & ((use_a_i & hit_a) | (use_b_i & hit_b));
  end

endmodule

// File: rtl/pipeline_ctrl_8085.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_8085
// Control and hazard scheduler for the 4-stage 8085 pipeline (IF/ID/EX/WB).
// Keeps shadow valid/destination state for ID, EX and WB, stalls on RAW
// hazards, flushes on taken branches and sequences HLT / resume.
// Ports:
//   clk, rst_n          - clock (rising edge), synchronous active-low reset
//   id_src_a/id_use_a   - ID first source and read enable
//   id_src_b/id_use_b   - ID second source and read enable
//   id_dst/id_wr        - ID destination and write enable
//   id_hlt              - ID instruction is HLT
//   ex_br_taken         - branch in EX resolved taken (only meaningful if EX live)
//   resume              - leave HALTED
//   pc_en/pc_sel        - PC update enable and source select
//   ifid_en/ifid_flush  - IF/ID load enable and clear
//   idex_bubble         - insert NOP into ID/EX
//   id_valid            - ID holds a live instruction
//   halted              - processor halted
//   stall_count         - saturating count of RAW stall cycles
// All outputs are forced to zero while rst_n is low.
// ---------------------------------------------------------------------------
module pipeline_ctrl_8085 #(
  parameter int unsigned REG_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_src_a,
  input  logic             id_use_a,
  input  logic [REG_W-1:0] id_src_b,
  input  logic             id_use_b,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_wr,
  input  logic             id_hlt,
  input  logic             ex_br_taken,
  input  logic             resume,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             id_valid,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);
  import pipe_8085_pkg::*;

  // Registered state
  state_e           state_q, state_d;
  logic             id_v_q, id_v_d;
  stage_t           ex_q, ex_d;
  logic             wb_v_q, wb_wr_q;
  logic [REG_W-1:0] wb_dst_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Combinational decisions
  logic    raw;
  logic    br;
  logic    hl;
  logic    pc_en_c;
  pc_sel_e pc_sel_c;
  logic    ifid_en_c;
  logic    flush_c;
  logic    bubble_c;
  logic    hold_c;

  hazard_detect_8085 #(
    .REG_W (REG_W)
  ) u_hazard (
    .id_v_i   (id_v_q),
    .src_a_i  (id_src_a),
    .use_a_i  (id_use_a),
    .src_b_i  (id_src_b),
    .use_b_i  (id_use_b),
    .ex_v_i   (ex_q.v),
    .ex_wr_i  (ex_q.wr),
    .ex_dst_i (ex_q.dst),
    .wb_v_i   (wb_v_q),
    .wb_wr_i  (wb_wr_q),
    .wb_dst_i (wb_dst_q),
    .raw_o    (raw)
  );

  assign br = ex_q.v & ex_br_taken;
  assign hl = ex_q.v & ex_q.hlt;

  // Next-state and control outputs. Branch beats HLT beats RAW; a flush
  // cycle discards the ID instruction, so its hazard is irrelevant and is
  // neither stalled on nor counted.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_en_c   = 1'b0;
    pc_sel_c  = PC_INC;
    ifid_en_c = 1'b0;
    flush_c   = 1'b0;
    bubble_c  = 1'b0;
    hold_c    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (br) begin
          pc_en_c   = 1'b1;
          pc_sel_c  = PC_BR;
          ifid_en_c = 1'b1;
          flush_c   = 1'b1;
          bubble_c  = 1'b1;
        end else if (hl) begin
          pc_en_c   = 1'b1;
          pc_sel_c  = PC_RST;
          ifid_en_c = 1'b1;
          flush_c   = 1'b1;
          bubble_c  = 1'b1;
          state_d   = ST_HALTED;
        end else if (raw) begin
          bubble_c = 1'b1;
          hold_c   = 1'b1;
          cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end else begin
          pc_en_c   = 1'b1;
          ifid_en_c = 1'b1;
        end
      end
      ST_HALTED: begin
        // Fetch is frozen; EX and WB drain through the bubbles.
        bubble_c = 1'b1;
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    ex_d = '0;
    if (!bubble_c) begin
      ex_d.v   = id_v_q;
      ex_d.dst = id_dst;
      ex_d.wr  = id_wr;
      ex_d.hlt = id_hlt;
    end

    if (flush_c)     id_v_d = 1'b0;
    else if (hold_c) id_v_d = id_v_q;
    else             id_v_d = pc_en_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      id_v_q   <= 1'b0;
      ex_q     <= '0;
      wb_v_q   <= 1'b0;
      wb_wr_q  <= 1'b0;
      wb_dst_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      id_v_q   <= id_v_d;
      ex_q     <= ex_d;
      wb_v_q   <= ex_q.v;
      wb_wr_q  <= ex_q.wr;
      wb_dst_q <= ex_q.dst;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs are gated by rst_n so the controller is quiet throughout reset,
  // not only after the first reset edge.
  assign pc_en       = rst_n & pc_en_c;
  assign pc_sel      = rst_n ? pc_sel_c : PC_INC;
  assign ifid_en     = rst_n & ifid_en_c;
  assign ifid_flush  = rst_n & flush_c;
  assign idex_bubble = rst_n & bubble_c;
  assign id_valid    = rst_n & id_v_q;
  assign halted      = rst_n & (state_q == ST_HALTED);
  assign stall_count = rst_n ? cnt_q : '0;

endmodule

// File: doc/pipeline_ctrl_8085.md
Name: pipeline_ctrl_8085

Overview:
Control and hazard scheduler for the 4-stage 8085 pipeline (IF, ID, EX, WB).
- Keeps a shadow of stage valid bits and destination registers.
- Detects RAW hazards on the register file, flushes on taken branches, and sequences HLT/resume.
- Drives PC enable/select, the IF/ID enable/flush and the ID/EX bubble. No datapath storage of its own.

Parameters:
- REG_W, 3, width of register index (regfile entries 0..6; index 7 is never written).
- CNT_W, 16, width of stall performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_src_a  in  REG_W  first source register of the instruction in ID.
- id_use_a  in  1  ID instruction reads id_src_a.
- id_src_b  in  REG_W  second source register of the instruction in ID.
- id_use_b  in  1  ID instruction reads id_src_b.
- id_dst  in  REG_W  destination register of the ID instruction.
- id_wr  in  1  ID instruction writes id_dst.
- id_hlt  in  1  ID instruction is HLT.
- ex_br_taken  in  1  branch resolved taken in EX (valid only when EX is valid).
- resume  in  1  interrupt/restart pulse; leaves HALTED.
- pc_en  out  1  PC update enable.
- pc_sel  out  2  0 = PC+1, 1 = EX branch target, 2 = EX PC+1 (halt restart point).
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID register clear.
- idex_bubble  out  1  insert NOP into ID/EX.
- id_valid  out  1  ID holds a live instruction.
- halted  out  1  processor halted.
- stall_count  out  CNT_W  saturating count of RAW stall cycles.

Behaviour:
- Reset (rst_n=0 at posedge):
  - id_v, ex_v, wb_v and ex_hlt are cleared; state=RUN; stall_count=0.
  - All outputs are 0 while rst_n=0, including pc_en, idex_bubble and halted.
- States:
  - RUN, HALTED.
- Shadow pipeline, registered each posedge:
  - wb <= ex.
  - ex <= bubble ? empty : {id_v, id_dst, id_wr, id_hlt}.
  - id_v <= flush ? 0 : (hold ? id_v : pc_en).
- Hazard (combinational):
  - raw = id_v & ((id_use_a & hit(id_src_a)) | (id_use_b & hit(id_src_b))).
  - hit(r) = (ex_v & ex_wr & ex_dst==r) | (wb_v & wb_wr & wb_dst==r).
  - No forwarding: a dependent instruction waits until the producer has left WB (write at WB edge, read in ID the next cycle).
- Priority in RUN, highest first:
  1. br = ex_v & ex_br_taken: pc_sel=1, pc_en=1, ifid_flush=1, idex_bubble=1.
  2. hl = ex_v & ex_hlt: pc_sel=2, pc_en=1, ifid_flush=1, idex_bubble=1; next state HALTED.
  3. raw: pc_en=0, ifid_en=0, idex_bubble=1; stall_count += 1, saturating at all-ones.
  4. Otherwise: pc_en=1, ifid_en=1, pc_sel=0, idex_bubble=0.
- In rows 1 and 2, ifid_en=1 together with ifid_flush=1 (the clear wins). raw is ignored in those cycles, and stall_count does not increment.
- flush = row 1 or 2; hold = row 3.
- HALTED:
  - pc_en=0, ifid_en=0, idex_bubble=1, halted=1; EX/WB drain naturally.
  - resume=1 leads to RUN on the next edge; fetch restarts that cycle from the PC loaded in the halt cycle.
  - resume in RUN is ignored.
  - ex_br_taken is ignored while ex_v=0.
- Latency:
  - Taken-branch penalty is 2 cycles (the IF and ID instructions are killed).
  - A RAW stall lasts 1–2 cycles depending on whether the producer is in EX or WB.
- Reset mid-stall or while halted: everything returns to the reset state on that edge; pending hazards are discarded.

Decomposition:
- Package pipe_8085_pkg holds:
  - state enum {RUN, HALTED}.
  - pc_sel encodings PC_INC=0, PC_BR=1, PC_RST=2.
  - REG_W.
  - stage record {v, dst, wr, hlt}.
- One natural sub-module: hazard_detect_8085, the combinational raw comparator over two sources against the EX and WB shadows.
- Counter and FSM stay in the top.

Test Plan:
1. Reset with rst_n=0 for 2 cycles, then release with independent instructions: pc_en=1 every cycle, id_valid=1 from the 2nd cycle after release, stall_count=0.
2. Instruction writing reg 0 followed by one reading reg 0 (id_use_a=1, id_src_a=0): idex_bubble=1 and pc_en=0 for exactly 2 cycles; stall_count=2; id_valid held at 1.
3. ex_br_taken=1 with EX valid: that cycle pc_sel=1, ifid_flush=1, idex_bubble=1; next cycle id_valid=0; no stall.
4. Taken branch in EX while ID has a RAW hit: flush wins, pc_en=1, stall_count unchanged.
5. HLT reaches EX: pc_sel=2 for 1 cycle, then halted=1 and pc_en=0 for 10 cycles. resume pulse brings halted=0 and pc_en=1 next cycle. A resume in RUN has no effect.
6. Assert rst_n=0 during the 2nd stall cycle and separately while HALTED: next cycle all outputs are 0, stall_count=0; after release the controller behaves as in scenario 1.
